// File: rtl/mux_pkg.sv
// mux_n1_rr shared definitions.
// Mode encodings and cyclic index helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned next_idx(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Cyclic-priority arbiter for mux_n1_rr.
// Picks the first request at or after ptr.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  int c;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    c           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = 32'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_n1_rr.sv
// N:1 mux with registered output stage.
// Fixed-select or round-robin channel choice.
module mux_n1_rr
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic            mode,
  input  logic [SELW-1:0] s,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SELW-1:0] y_sel
);

  logic [W-1:0]    y_q;
  logic            y_valid_q;
  logic [SELW-1:0] y_sel_q;
  logic [SELW-1:0] ptr_q;

  logic            load_en;
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            fix_valid;
  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data;

  assign load_en = !y_valid_q || y_ready;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req         (i_valid),
    .ptr         (ptr_q),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Fixed candidate is s, but only when it names a real channel.
  always_comb begin
    fix_valid = 1'b0;
    if (32'(s) < N) fix_valid = i_valid[s];
  end

  // Choose grant source by mode and fetch the granted word.
  always_comb begin
    if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fix_valid;
      gnt_idx   = s;
    end
    gnt_data = i[32'(gnt_idx)*W +: W];
  end

  // One-hot ready to the granted channel; silent during reset.
  always_comb begin
    i_ready = '0;
    if (!rst && load_en && gnt_valid) i_ready[gnt_idx] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
      ptr_q     <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        y_q       <= gnt_data;
        y_sel_q   <= gnt_idx;
        y_valid_q <= 1'b1;
        if (mode == MODE_RR)
          ptr_q <= SELW'(next_idx(32'(gnt_idx), N));
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_sel   = y_sel_q;

endmodule
